xpb_lut_gen: RTL
================

Name: xpb_lut_gen

Overview:
- Runtime-generated, parametrised replacement for fixed constant xpb lookup tables in the modular squaring datapath.
- Takes a BASE constant and fills 2^IDX_W entries with entry[k] = k*BASE mod 2^DATA_W, one entry per cycle, using a sequential accumulator.
- After generation it serves registered lookups with a valid/ready handshake.
- Lets one RTL block cover every xpb slice and modulus without regenerating hardcoded case tables.

Parameters:
- IDX_W, 5, index width; table depth = 2^IDX_W.
- DATA_W, 1024, entry width in bits; all arithmetic is mod 2^DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- gen_start  in  1  start generation; single-cycle sample.
- gen_base  in  DATA_W  BASE constant, captured on the edge where gen_start is accepted.
- gen_busy  out  1  high while in GEN.
- gen_done  out  1  one-cycle pulse when the table is complete.
- table_valid  out  1  table contents usable.
- lkp_valid  in  1  lookup request.
- lkp_idx  in  IDX_W  lookup index.
- lkp_ready  out  1  lookup can be accepted; equals table_valid & ~gen_busy.
- out_valid  out  1  one-cycle pulse carrying a lookup result.
- out_data  out  DATA_W  lookup result, held until the next result.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; gen_busy=0, gen_done=0, table_valid=0, out_valid=0, out_data=0.
  - Internal counter and accumulator cleared.
  - Entry storage is not reset; its contents are don't-care while table_valid=0.
- States and transitions:
  - IDLE: gen_start -> GEN. Lookups are not accepted.
  - GEN:
    - The entry edge captures base_r=gen_base and sets cnt=0, acc=0.
    - Each GEN-cycle edge writes entry[cnt]=acc, then acc=acc+base_r (carry beyond DATA_W discarded), cnt=cnt+1.
    - The edge that writes cnt=2^IDX_W-1 moves to READY.
  - READY: table_valid=1. gen_start -> GEN, with table_valid cleared on the same edge.
- Generation timing:
  - gen_start sampled at edge T.
  - gen_busy is high for exactly 2^IDX_W cycles (after edges T .. T+2^IDX_W-1).
  - gen_done and table_valid rise after edge T+2^IDX_W.
  - gen_done lasts exactly one cycle.
- Generation boundary conditions:
  - gen_start during GEN is ignored; no restart and base_r is unchanged.
  - entry[0] is always 0.
  - BASE=0 yields an all-zero table.
  - A reset mid-GEN returns to IDLE with table_valid=0; no partial table is ever flagged valid.
- Lookup:
  - A request is accepted when lkp_valid & lkp_ready at an edge.
  - At that edge out_data<=entry[lkp_idx] and out_valid<=1, so latency is 1 cycle.
  - Back-to-back lookups give one result per cycle.
  - out_valid is low in any cycle with no accepted request; out_data holds its last value.
  - lkp_valid while lkp_ready=0 is dropped. The requester must hold the request until it is accepted.
  - gen_start and an accepted lookup on the same READY edge: the lookup completes with the old table, then GEN starts.
- No combinational path from any input to any output, except lkp_ready, which depends only on state.

Optional Feature:
- Macro: XPB_LUT_DIRECT_WR_EN.
- When defined, three extra inputs are present: wr_en (1), wr_idx (IDX_W), wr_data (DATA_W).
  - wr_en in IDLE or READY writes entry[wr_idx]=wr_data; in IDLE it also moves to READY and sets table_valid=1.
  - wr_en during GEN is ignored.
  - A write and a lookup to the same index on the same edge: the lookup returns the pre-write value (read-before-write).
  - wr_en together with gen_start: gen_start has priority and the write is dropped.
- When not defined, the ports are absent and the table is only ever filled by generation.

Test Plan:
- DATA_W=64, IDX_W=5, base=1; pulse gen_start -> gen_busy high exactly 32 cycles, then gen_done one cycle; lookups idx 0, 17, 31 -> out_data 0, 17, 31, each one cycle after acceptance.
- DATA_W=16, base=16'hFFFF -> idx 3 returns 16'hFFFD; idx 31 returns 16'hFFE1 (wrap-around).
- DATA_W=1024, base=0x10ec13be...cff7 (production xpb_5_145 constant) -> idx 16 equals base<<4 mod 2^1024; idx 31 equals 31*base mod 2^1024.
- Lookups issued every cycle with lkp_valid held high across a mid-stream gen_start -> lkp_ready drops for 32 cycles, no out_valid during GEN, results after gen_done reflect the new base.
- Assert rst_n low at GEN cycle 10 -> outputs 0 asynchronously, table_valid=0, lkp_ready=0; a following gen_start completes normally.
- XPB_LUT_DIRECT_WR_EN defined: from IDLE, wr_en idx 4 = 0xABCD -> table_valid=1; same-edge write idx 4 = 0x1234 plus lookup idx 4 -> 0xABCD, then the next lookup returns 0x1234.

Source files
------------

// File: rtl/xpb_lut_gen.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_lut_gen
//  Brief    : Runtime-generated xpb lookup table. Fills 2^IDX_W entries with
//             entry[k] = k*BASE mod 2^DATA_W using a sequential accumulator,
//             then serves registered lookups over a valid/ready handshake.
//  Options  : XPB_LUT_DIRECT_WR_EN adds a direct table write port
//             (wr_en_i / wr_idx_i / wr_data_i).
//  Revision : 1.0  initial release
// ============================================================================
module xpb_lut_gen #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              gen_start_i,
  input  logic [DATA_W-1:0] gen_base_i,
  output logic              gen_busy_o,
  output logic              gen_done_o,
  output logic              table_valid_o,
`ifdef XPB_LUT_DIRECT_WR_EN
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
`endif
  input  logic              lkp_valid_i,
  input  logic [IDX_W-1:0]  lkp_idx_i,
  output logic              lkp_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   base_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   acc_d;
  logic [IDX_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    cnt_d;
  logic                gen_busy_q;
  logic                gen_done_q;
  logic                table_valid_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                lkp_accept;
`ifdef XPB_LUT_DIRECT_WR_EN
  logic                wr_accept;
`endif

  // Table is only readable in READY; table_valid is cleared on GEN entry,
  // so it alone encodes "READY with a complete table".
  assign lkp_ready_o = table_valid_q;
  assign lkp_accept  = lkp_valid_i & table_valid_q;

  // Running multiple of BASE; carry beyond DATA_W drops naturally.
  assign acc_d = acc_q + base_q;
  assign cnt_d = cnt_q + CNT_ONE;

`ifdef XPB_LUT_DIRECT_WR_EN
  // Direct writes lose to gen_start and are ignored while generating.
  assign wr_accept = wr_en_i & ~gen_start_i & (state_q != ST_GEN);
`endif

  // Control FSM: generation sequencing, status flags and accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      gen_busy_q    <= 1'b0;
      gen_done_q    <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (gen_start_i) begin
            state_q       <= ST_GEN;
            base_q        <= gen_base_i;
            acc_q         <= '0;
            cnt_q         <= '0;
            gen_busy_q    <= 1'b1;
            table_valid_q <= 1'b0;
          end
`ifdef XPB_LUT_DIRECT_WR_EN
          else if (wr_accept) begin
            state_q       <= ST_READY;
            table_valid_q <= 1'b1;
          end
`endif
        end
        ST_GEN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_q == LAST_IDX) begin
            state_q       <= ST_READY;
            gen_busy_q    <= 1'b0;
            gen_done_q    <= 1'b1;
            table_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          gen_busy_q    <= 1'b0;
          table_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: generation writes one entry per GEN cycle; contents are
  // meaningless until table_valid, so no reset is applied.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_GEN) begin
      mem_q[cnt_q] <= acc_q;
    end
`ifdef XPB_LUT_DIRECT_WR_EN
    else if (wr_accept) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
`endif
  end

  // Lookup result register: one-cycle latency, read-before-write on the array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= lkp_accept;
      if (lkp_accept) begin
        out_data_q <= mem_q[lkp_idx_i];
      end
    end
  end

  assign gen_busy_o    = gen_busy_q;
  assign gen_done_o    = gen_done_q;
  assign table_valid_o = table_valid_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;

endmodule
`default_nettype wire
